// File: rtl/servo_pkg.sv
// Shared constants and types for the servo PWM transmitter/receiver pair.
// Tick clock is 10 kHz, so one tick is 100 us.
package servo_pkg;

  localparam int TICK_HZ         = 10000;
  localparam int PERIOD_COUNT    = 240;
  localparam int LOW_WIDTH       = 11;
  localparam int HIGH_WIDTH      = 19;
  localparam int NEUTRAL_WIDTH   = 15;
  localparam int SLEW_STEP       = 2;
  localparam int FAILSAFE_FRAMES = 3;

  // Receiver acceptance windows; transmitter widths must stay inside them.
  localparam int MIN_HIGH_COUNT  = 5;
  localparam int MAX_HIGH_COUNT  = 30;
  localparam int MIN_LOW_COUNT   = 231;
  localparam int MAX_LOW_COUNT   = 250;

  typedef logic [4:0] width_t;
  typedef logic [7:0] count_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tmr_state_t;

  // Move cur toward tgt by at most step; never overshoots.
  function automatic width_t slew_toward(input width_t cur, input width_t tgt,
                                         input width_t step);
    width_t diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return cur + ((diff > step) ? step : diff);
    end else begin
      diff = cur - tgt;
      return cur - ((diff > step) ? step : diff);
    end
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame sequencer: owns the run state, tick counter and deferred stop.
// A stop request only takes effect at the wrap so a frame is never truncated.
import servo_pkg::*;

module servo_frame_timer #(
  parameter int PERIOD_COUNT = servo_pkg::PERIOD_COUNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       boundary,
  output logic       frame_start,
  output tmr_state_t state_next,
  output count_t     cnt_next
);

  localparam count_t LAST = count_t'(PERIOD_COUNT - 1);

  tmr_state_t state_q;
  count_t     cnt_q;
  logic       stop_pending_q;
  logic       stop_pending_d;

  always_comb begin
    state_next     = state_q;
    cnt_next       = cnt_q;
    stop_pending_d = stop_pending_q;
    boundary       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop_pending_d = 1'b0;
        if (enable) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          boundary   = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST) begin
          cnt_next = '0;
          if (stop_pending_q) begin
            state_next     = ST_IDLE;
            stop_pending_d = 1'b0;
          end else begin
            boundary       = 1'b1;
            stop_pending_d = !enable;
          end
        end else begin
          cnt_next       = cnt_q + 8'd1;
          stop_pending_d = !enable;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      stop_pending_q <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      state_q        <= state_next;
      cnt_q          <= cnt_next;
      stop_pending_q <= stop_pending_d;
      frame_start    <= boundary;
    end
  end

endmodule

// File: rtl/logic_to_servo.sv
// Servo PWM transmitter: encodes a logic level as a slew-limited pulse width,
// updated only at frame boundaries, with a neutral failsafe on repeated faults.
import servo_pkg::*;

module logic_to_servo #(
  parameter int PERIOD_COUNT    = servo_pkg::PERIOD_COUNT,
  parameter int LOW_WIDTH       = servo_pkg::LOW_WIDTH,
  parameter int HIGH_WIDTH      = servo_pkg::HIGH_WIDTH,
  parameter int NEUTRAL_WIDTH   = servo_pkg::NEUTRAL_WIDTH,
  parameter int SLEW_STEP       = servo_pkg::SLEW_STEP,
  parameter int FAILSAFE_FRAMES = servo_pkg::FAILSAFE_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       log,
  input  logic       in_fault,
  output logic       servo,
  output logic       frame_start,
  output logic [4:0] width,
  output logic       failsafe,
  output logic       settled
);

  localparam width_t     W_LOW     = width_t'(LOW_WIDTH);
  localparam width_t     W_HIGH    = width_t'(HIGH_WIDTH);
  localparam width_t     W_NEUTRAL = width_t'(NEUTRAL_WIDTH);
  localparam width_t     W_STEP    = width_t'(SLEW_STEP);
  localparam logic [2:0] FS_THR    = 3'(FAILSAFE_FRAMES);

  logic       boundary;
  tmr_state_t state_next;
  count_t     cnt_next;

  logic       last_good_q, last_good_d;
  logic [2:0] fault_cnt_q, fault_cnt_d;
  logic       failsafe_d;
  width_t     width_d;
  logic       servo_d;

  function automatic width_t target_of(input logic fs, input logic lg);
    return fs ? W_NEUTRAL : (lg ? W_HIGH : W_LOW);
  endfunction

  servo_frame_timer #(
    .PERIOD_COUNT (PERIOD_COUNT)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .boundary    (boundary),
    .frame_start (frame_start),
    .state_next  (state_next),
    .cnt_next    (cnt_next)
  );

  // Inputs are sampled only on boundary edges; the new width applies to the
  // frame that starts on that same edge.
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    failsafe_d  = failsafe;
    last_good_d = last_good_q;
    width_d     = width;
    if (boundary) begin
      if (in_fault) begin
        fault_cnt_d = (fault_cnt_q == 3'd7) ? 3'd7 : fault_cnt_q + 3'd1;
        failsafe_d  = failsafe | (fault_cnt_d >= FS_THR);
      end else begin
        fault_cnt_d = '0;
        failsafe_d  = 1'b0;
        last_good_d = log;
      end
      width_d = slew_toward(width, target_of(failsafe_d, last_good_d), W_STEP);
    end
  end

  assign servo_d = (state_next == ST_RUN) && (cnt_next < {3'b000, width_d});
  assign settled = (width == target_of(failsafe, last_good_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width       <= W_NEUTRAL;
      last_good_q <= 1'b0;
      fault_cnt_q <= FS_THR;
      failsafe    <= 1'b1;
      servo       <= 1'b0;
    end else begin
      width       <= width_d;
      last_good_q <= last_good_d;
      fault_cnt_q <= fault_cnt_d;
      failsafe    <= failsafe_d;
      servo       <= servo_d;
    end
  end

endmodule

// File: doc/logic_to_servo.md
# logic_to_servo

Servo-PWM transmitter: converts a logic level into a standard servo control pulse train on the 10 kHz tick clock (1 tick = 100 µs). It is the send-side counterpart of the servo-to-logic receiver, and its output must be accepted by that receiver with the same parameter set. Width changes are slew-limited and applied only at frame boundaries. A failsafe drives neutral after repeated upstream faults.

## Interface
Parameters:
- PERIOD_COUNT, 240: ticks per frame; must be ≤ 256.
- LOW_WIDTH, 11: pulse ticks encoding logic 0.
- HIGH_WIDTH, 19: pulse ticks encoding logic 1.
- NEUTRAL_WIDTH, 15: failsafe and post-reset pulse ticks.
- SLEW_STEP, 2: maximum width change per frame, in ticks; ≥ 1.
- FAILSAFE_FRAMES, 3: consecutive faulted frame boundaries before failsafe; 1..7.

Ports:
- clk  in  1  10 kHz tick clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- log  in  1  requested level.
- in_fault  in  1  upstream data invalid.
- servo  out  1  PWM output, driven from a flop.
- frame_start  out  1  one-cycle pulse on the first tick of each frame.
- width  out  5  width of the current frame, in ticks.
- failsafe  out  1  neutral override active.
- settled  out  1  width equals the current target.

## Operation
- Registered state:
  - running.
  - cnt[7:0].
  - width[4:0].
  - last_good.
  - fault_cnt[2:0].
  - failsafe.
  - stop_pending.
- States: IDLE (running=0) and RUN (running=1).
- IDLE to RUN on an edge with enable=1. That edge is a boundary edge.
- In RUN: cnt <= (cnt==PERIOD_COUNT-1) ? 0 : cnt+1.
  - The wrap edge is a boundary edge unless stop_pending=1.
  - If stop_pending=1 at the wrap edge, go to IDLE instead.
- enable=0 while in RUN sets stop_pending. The current frame always completes: no truncated pulse, no truncated low time.
- enable back to 1 before the wrap clears stop_pending.
- Boundary edge actions:
  - frame_start<=1.
  - cnt<=0.
  - If in_fault=1: fault_cnt saturating +1; failsafe<=1 when the new fault_cnt ≥ FAILSAFE_FRAMES.
  - If in_fault=0: fault_cnt<=0, failsafe<=0, last_good<=log.
  - target = new failsafe ? NEUTRAL_WIDTH : (new last_good ? HIGH_WIDTH : LOW_WIDTH).
  - width moves toward target by min(SLEW_STEP, |target−width|).
- While faulted but below threshold, target keeps last_good. log is ignored while in_fault=1.
- servo invariant: servo==running && (cnt < width) after every edge. It is never high in IDLE.
- settled = (width == target). target is computed combinationally from the registered failsafe and last_good.
- Width arithmetic is 5-bit unsigned. The step cannot overshoot.
- Legal widths are 6..29 and must fit inside the receiver's high-time window. PERIOD_COUNT must satisfy the receiver's 231..250 low-count window.
- Reset values:
  - running=0, cnt=0.
  - width=NEUTRAL_WIDTH.
  - last_good=0.
  - fault_cnt=FAILSAFE_FRAMES.
  - failsafe=1 (mirrors the receiver's rx_problem=1).
  - stop_pending=0.
  - servo=0, frame_start=0, settled=1.

## Timing
- log and in_fault are sampled only at boundary edges.
- Latency from the sample to the changed pulse: 0 cycles. The new width applies to the frame starting on that edge.
- Worst case from input change to first affected frame: PERIOD_COUNT cycles.
- Full LOW↔HIGH swing takes ceil(8/SLEW_STEP)=4 frames.
- frame_start period = PERIOD_COUNT cycles exactly while running.
- Enable to first frame_start: 1 edge from IDLE.
- Enable drop: servo stays low from the end of the current frame until restart.
- in_fault toggling between boundaries has no effect.
- Simultaneous events on a boundary edge: enable low plus wrap with stop_pending already set means IDLE wins; no frame_start.
- Reset asserted mid-pulse: servo falls immediately (asynchronously). The next frame after release starts at neutral width.

## Structure
- Shared package servo_pkg:
  - TICK_HZ=10000.
  - PERIOD_COUNT, LOW_WIDTH, HIGH_WIDTH, NEUTRAL_WIDTH.
  - Receiver limits MIN/MAX_HIGH_COUNT and MIN/MAX_LOW_COUNT.
  - Types width_t (logic[4:0]) and count_t (logic[7:0]).
- One sub-module, servo_frame_timer:
  - Owns running, cnt, stop_pending and frame_start.
  - Exports a boundary strobe.
  - Width, slew and failsafe logic stay in logic_to_servo.

## Test plan
- Reset, enable=1, log=0, in_fault=0 → successive frame widths 13, 11, 11. failsafe drops at the first boundary. frame_start every 240 cycles. servo high exactly width cycles from frame_start.
- Settled at LOW, log 0→1 mid-frame → next frames 13, 15, 17, 19. settled=1 from the 19-tick frame onward.
- in_fault=1 for 2 boundaries → width unchanged, failsafe=0. 3rd boundary → failsafe=1, width steps toward 15. in_fault=0 with log=1 → failsafe=0, slew to 19.
- enable=0 at cnt=5 of a 19-tick frame → full 19-tick pulse and low time to cnt=239, then servo=0 and no frame_start. enable=1 → frame_start on the next edge.
- Loopback into the receiver, same clk, edge detection added → rx_problem=0 after the second pulse. Receiver log tracks the transmitter's last_good once settled. Receiver log never glitches during slew.
- rst_n low during the high phase → servo=0 within the same cycle. After release, first frame width 15.
